// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared state encoding and widths for the run-and-dump debug controller.
package proc_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RUN          = 3'd1,
    ST_DUMP_SETUP   = 3'd2,
    ST_DUMP_PRESENT = 3'd3,
    ST_DONE         = 3'd4
  } dump_state_e;

  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W       = 32;
  localparam int IDX_W        = 6;

  localparam logic [IDX_W-1:0] CHECKSUM_IDX = 6'd32;

  function automatic logic in_dump(input dump_state_e st);
    return (st == ST_DUMP_SETUP) || (st == ST_DUMP_PRESENT);
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Valid/ready stream carrying the register image out of the dump controller.
interface regfile_dump_ctrl_if;
  import proc_dbg_pkg::*;

  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [IDX_W-1:0]  dump_idx;
  logic              dump_last;

  modport master (output dump_valid, output dump_data, output dump_idx,
                  output dump_last, input dump_ready);
  modport slave  (input dump_valid, input dump_data, input dump_idx,
                  input dump_last, output dump_ready);
endinterface

// File: rtl/regfile_dump_ctrl_cycle_budget_ctr.sv
// Cycle budget latch and run counter; tc flags the last released cycle,
// zero flags a budget of 0 so the run phase can be skipped.
module cycle_budget_ctr #(
  parameter int CYC_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CYC_W-1:0] num_cycles,
  output logic [CYC_W-1:0] count,
  output logic             tc,
  output logic             zero
);

  localparam logic [CYC_W-1:0] ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  logic [CYC_W-1:0] budget_q, budget_d;
  logic [CYC_W-1:0] count_q, count_d;

  always_comb begin
    budget_d = budget_q;
    count_d  = count_q;
    if (load) begin
      budget_d = num_cycles;
      count_d  = {CYC_W{1'b0}};
    end else if (en) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      budget_q <= {CYC_W{1'b0}};
      count_q  <= {CYC_W{1'b0}};
    end else begin
      budget_q <= budget_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == (budget_q - ONE));
  assign zero  = (num_cycles == {CYC_W{1'b0}});

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Run-and-dump controller: runs the processor for a cycle budget, then sweeps
// regfile port A and streams each register. Option: REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_ctrl
  import proc_dbg_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int CYC_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [CYC_W-1:0]    num_cycles,
  output logic                cpu_halt,
  output logic                test_mode,
  output logic [4:0]          test_reg,
  input  logic [DATA_W-1:0]   regA,
  regfile_dump_ctrl_if.master dump,
  output logic                busy,
  output logic                done,
  output logic [CYC_W-1:0]    cycle_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  dump_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              cpu_halt_q, cpu_halt_d;
  logic              test_mode_q, test_mode_d;
  logic [4:0]        test_reg_q, test_reg_d;
  logic              dump_valid_q, dump_valid_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic [IDX_W-1:0]  dump_idx_q, dump_idx_d;
  logic              dump_last_q, dump_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ctr_load, ctr_en, ctr_tc, ctr_zero;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  cycle_budget_ctr #(.CYC_W(CYC_W)) u_ctr (
    .clock      (clock),
    .reset      (reset),
    .load       (ctr_load),
    .en         (ctr_en),
    .num_cycles (num_cycles),
    .count      (cycle_count),
    .tc         (ctr_tc),
    .zero       (ctr_zero)
  );

  assign ctr_en = (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_data_d = dump_data_q;
    dump_idx_d  = dump_idx_q;
    dump_last_d = dump_last_q;
    ctr_load    = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          ctr_load    = 1'b1;
          idx_d       = {IDX_W{1'b0}};
          dump_last_d = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          sum_d       = {DATA_W{1'b0}};
`endif
          state_d     = ctr_zero ? ST_DUMP_SETUP : ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        state_d = ctr_tc ? ST_DUMP_SETUP : ST_RUN;
      end
      ST_DUMP_SETUP: begin
        dump_data_d = regA;
        dump_idx_d  = idx_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        dump_last_d = 1'b0;
        sum_d       = sum_q + regA;
`else
        dump_last_d = (idx_q == LAST_IDX);
`endif
        state_d     = ST_DUMP_PRESENT;
      end
      ST_DUMP_PRESENT: begin
        if (dump.dump_ready) begin
          if (dump_last_q) begin
            state_d = ST_DONE;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          // Checksum word follows the last register with no setup cycle.
          end else if (idx_q == LAST_IDX) begin
            dump_data_d = sum_q;
            dump_idx_d  = CHECKSUM_IDX;
            dump_last_d = 1'b1;
            state_d     = ST_DUMP_PRESENT;
`endif
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_DUMP_SETUP;
          end
        end else begin
          state_d = ST_DUMP_PRESENT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they change with it.
    cpu_halt_d   = (state_d != ST_RUN);
    test_mode_d  = in_dump(state_d);
    test_reg_d   = idx_d[4:0];
    dump_valid_d = (state_d == ST_DUMP_PRESENT);
    busy_d       = (state_d == ST_RUN) || in_dump(state_d);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= {IDX_W{1'b0}};
      cpu_halt_q   <= 1'b1;
      test_mode_q  <= 1'b0;
      test_reg_q   <= 5'd0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= {DATA_W{1'b0}};
      dump_idx_q   <= {IDX_W{1'b0}};
      dump_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      sum_q        <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cpu_halt_q   <= cpu_halt_d;
      test_mode_q  <= test_mode_d;
      test_reg_q   <= test_reg_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_idx_q   <= dump_idx_d;
      dump_last_q  <= dump_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign cpu_halt        = cpu_halt_q;
  assign test_mode       = test_mode_q;
  assign test_reg        = test_reg_q;
  assign dump.dump_valid = dump_valid_q;
  assign dump.dump_data  = dump_data_q;
  assign dump.dump_idx   = dump_idx_q;
  assign dump.dump_last  = dump_last_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: run budget, dump order/data, stalls,
// mid-run reset, start filtering and (with REGFILE_DUMP_CHECKSUM_EN) the checksum word.
module tb_regfile_dump_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  num_cycles;
  logic        cpu_halt;
  logic        test_mode;
  logic [4:0]  test_reg;
  logic [31:0] regA;
  logic        busy;
  logic        done;
  logic [7:0]  cycle_count;
  logic [31:0] rf [32];

  int n_tests = 0;
  int n_fail  = 0;
  int r_words, r_halt, r_setup, r_done, r_stall, r_last_idx;
  logic [31:0] r_last_data;

  regfile_dump_ctrl_if dump_if ();

  regfile_dump_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_cycles  (num_cycles),
    .cpu_halt    (cpu_halt),
    .test_mode   (test_mode),
    .test_reg    (test_reg),
    .regA        (regA),
    .dump        (dump_if),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count)
  );

  assign regA = rf[test_reg];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int k);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < 32; i++) s = s + rf[i];
    return (k < 32) ? rf[k] : s;
  endfunction

  function automatic logic exp_last(input int k);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    return (k == 32);
`else
    return (k == 31);
`endif
  endfunction

  task automatic fill_rf(input int mult);
    for (int i = 0; i < 32; i++) rf[i] = i * mult;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    @(posedge clock); #1;
    start = 1'b1;
    num_cycles = n;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Watches one run until done: counts released cycles, checks every presented
  // word against the model, drives ready and optionally pokes start mid-dump.
  task automatic run_dump(input bit free_rdy, input int stall_idx, input int stall_n,
                          input int poke_at);
    int   k;
    int   stalls;
    logic rdy_next;
    k = 0; stalls = 0;
    r_halt = 0; r_setup = -1; r_done = -1; r_stall = 0;
    r_last_idx = -1; r_last_data = 32'd0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (!cpu_halt) r_halt++;
      if (test_mode && r_setup < 0) r_setup = n;
      if (done) begin
        r_done = n;
        break;
      end
      rdy_next = free_rdy;
      if (dump_if.dump_valid) begin
        check_val("word_idx", {26'd0, dump_if.dump_idx}, k);
        check_val("word_data", dump_if.dump_data, exp_data(k));
        check_val("word_last", {31'd0, dump_if.dump_last}, {31'd0, exp_last(k)});
        if (dump_if.dump_ready) begin
          r_last_idx  = dump_if.dump_idx;
          r_last_data = dump_if.dump_data;
          k++;
        end else if (dump_if.dump_idx == stall_idx) begin
          r_stall++;
        end
        if (!free_rdy) begin
          if (dump_if.dump_idx == stall_idx && stalls < stall_n) begin
            stalls++;
            rdy_next = 1'b0;
          end else begin
            rdy_next = 1'b1;
          end
        end
      end
      @(posedge clock); #1;
      dump_if.dump_ready = rdy_next;
      if (poke_at >= 0) begin
        start      = (n >= poke_at) && (n < poke_at + 2);
        num_cycles = 8'd7;
      end
    end
    r_words = k;
    check_val("dump_finished", {31'd0, (r_done >= 0)}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt, hcnt;
    reset = 1'b1; start = 1'b0; num_cycles = 8'd0; dump_if.dump_ready = 1'b1;
    fill_rf(3);
    repeat (2) @(negedge clock);
    check_val("rst_cpu_halt", {31'd0, cpu_halt}, 32'd1);
    check_val("rst_test_mode", {31'd0, test_mode}, 32'd0);
    check_val("rst_test_reg", {27'd0, test_reg}, 32'd0);
    check_val("rst_valid", {31'd0, dump_if.dump_valid}, 32'd0);
    check_val("rst_data", dump_if.dump_data, 32'd0);
    check_val("rst_idx", {26'd0, dump_if.dump_idx}, 32'd0);
    check_val("rst_last", {31'd0, dump_if.dump_last}, 32'd0);
    check_val("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_val("rst_count", {24'd0, cycle_count}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Budget 10, r_i = 3i, ready tied high.
    pulse_start(8'd10);
    run_dump(1'b1, -1, 0, -1);
    check_val("a_halt_cycles", r_halt, 32'd10);
    check_val("a_count", {24'd0, cycle_count}, 32'd10);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    check_val("a_words", r_words, 32'd33);
`else
    check_val("a_words", r_words, 32'd32);
    check_val("a_last_idx", r_last_idx, 32'd31);
    check_val("a_last_data", r_last_data, 32'd93);
    check_val("a_dump_cycles", r_done - r_setup, 32'd64);
`endif
    check_val("a_done_flags", {29'd0, done, busy, cpu_halt}, 32'd5);
    check_val("a_idle_outs", {30'd0, test_mode, dump_if.dump_valid}, 32'd0);

    // Zero budget: dump begins right after the accepting edge.
    pulse_start(8'd0);
    run_dump(1'b1, -1, 0, -1);
    check_val("z_halt_cycles", r_halt, 32'd0);
    check_val("z_setup_at", r_setup, 32'd0);
    check_val("z_count", {24'd0, cycle_count}, 32'd0);

    // Stall on r5 = 0xDEADBEEF; every word also waits one cycle for ready.
    fill_rf(3);
    rf[5] = 32'hDEADBEEF;
    @(posedge clock); #1;
    dump_if.dump_ready = 1'b0;
    pulse_start(8'd3);
    run_dump(1'b0, 5, 3, -1);
    check_val("s_stall_cycles", r_stall, 32'd4);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    check_val("s_words", r_words, 32'd33);
`else
    check_val("s_words", r_words, 32'd32);
`endif
    dump_if.dump_ready = 1'b1;

    // Reset in the 4th released cycle of a 10-cycle run.
    fill_rf(3);
    pulse_start(8'd10);
    repeat (4) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check_val("r_cpu_halt", {31'd0, cpu_halt}, 32'd1);
    check_val("r_busy", {31'd0, busy}, 32'd0);
    check_val("r_count", {24'd0, cycle_count}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    vcnt = 0; hcnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (dump_if.dump_valid) vcnt++;
      if (!cpu_halt) hcnt++;
    end
    check_val("r_no_words", vcnt, 32'd0);
    check_val("r_stays_halted", hcnt, 32'd0);
    pulse_start(8'd10);
    run_dump(1'b1, -1, 0, -1);
    check_val("r_rerun_halt", r_halt, 32'd10);
    check_val("r_rerun_count", {24'd0, cycle_count}, 32'd10);

    // Start during the dump is ignored.
    pulse_start(8'd2);
    run_dump(1'b1, -1, 0, 20);
    check_val("e_halt_cycles", r_halt, 32'd2);
    check_val("e_count", {24'd0, cycle_count}, 32'd2);
    check_val("e_done", {31'd0, done}, 32'd1);

    // Start held three cycles in DONE is accepted once.
    @(posedge clock); #1;
    start = 1'b1; num_cycles = 8'd5;
    @(posedge clock); #1;
    check_val("e2_count_clr", {24'd0, cycle_count}, 32'd0);
    check_val("e2_flags", {29'd0, done, busy, cpu_halt}, 32'd2);
    @(posedge clock); #1;
    check_val("e2_count1", {24'd0, cycle_count}, 32'd1);
    @(posedge clock); #1;
    start = 1'b0;
    check_val("e2_count2", {24'd0, cycle_count}, 32'd2);
    run_dump(1'b1, -1, 0, -1);
    check_val("e2_halt_rest", r_halt, 32'd3);
    check_val("e2_count_end", {24'd0, cycle_count}, 32'd5);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    // Checksum over r_i = i is 496.
    fill_rf(1);
    pulse_start(8'd4);
    run_dump(1'b1, -1, 0, -1);
    check_val("c_words", r_words, 32'd33);
    check_val("c_sum_idx", r_last_idx, 32'd32);
    check_val("c_sum_data", r_last_data, 32'd496);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
